shot_resolver: RTL and testbench

- Game-logic stage directly upstream of the 100-cell grid array.
- Accepts one fire request per turn as a row/col coordinate and resolves it against a ship-ID map.
- Drives the grid's per-cell shot and ship_sunk strobes plus a static is_ship vector.
- Tracks per-ship hit counts, reports miss/hit/sunk/invalid per turn, and flags game over when every ship is sunk.

---
 rtl/shot_resolver.sv | 207 ++++++++++++++++++++
 tb/tb_shot_resolver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_resolver.sv
// ============================================================================
//  Module   : shot_resolver
//  Purpose  : Resolves one fire request per turn against a ship-ID map and
//             drives per-cell shot / ship_sunk strobes for the grid array.
//  Options  : ADJACENT_SINK_EN - sink mask also covers water cells touching
//             the sunk ship (8-neighbourhood, no wrap at grid edges).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shot_resolver #(
  parameter int GRID_N    = 10,
  parameter int NUM_SHIPS = 5,
  parameter int ID_W      = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            fire,
  input  logic [3:0]                      target_row,
  input  logic [3:0]                      target_col,
  input  logic [GRID_N*GRID_N*ID_W-1:0]   ship_map,
  output logic [GRID_N*GRID_N-1:0]        shot,
  output logic [GRID_N*GRID_N-1:0]        is_ship,
  output logic [GRID_N*GRID_N-1:0]        ship_sunk,
  output logic                            busy,
  output logic                            result_valid,
  output logic [1:0]                      result,
  output logic [ID_W-1:0]                 ships_left,
  output logic                            game_over
);

  localparam int NUM_CELLS = GRID_N * GRID_N;
  localparam int IDX_W     = $clog2(NUM_CELLS);
  localparam int CNT_W     = $clog2(NUM_CELLS + 1);

  localparam logic [1:0] c_RES_MISS    = 2'b00;
  localparam logic [1:0] c_RES_HIT     = 2'b01;
  localparam logic [1:0] c_RES_SUNK    = 2'b10;
  localparam logic [1:0] c_RES_INVALID = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_SINK    = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [NUM_CELLS-1:0]   r_shot;
  logic [NUM_CELLS-1:0]   r_sunk_mask;
  logic [NUM_CELLS-1:0]   r_fired;
  logic                   r_result_valid;
  logic [1:0]             r_result;
  logic                   r_game_over;
  logic [NUM_SHIPS-1:0]   r_sunk;
  logic                   r_sink_pend;
  logic [ID_W-1:0]        r_sink_id;
  logic [CNT_W-1:0]       r_hit [NUM_SHIPS];

  logic [ID_W-1:0]        w_id [NUM_CELLS];
  logic [CNT_W-1:0]       w_len [NUM_SHIPS];
  logic                   w_in_range;
  logic [IDX_W-1:0]       w_idx;
  logic [ID_W-1:0]        w_tid;
  logic [ID_W-1:0]        w_tk;
  logic [ID_W-1:0]        w_sink_k;
  logic                   w_valid;
  logic [NUM_CELLS-1:0]   w_own;
  logic [NUM_CELLS-1:0]   w_sink_mask;

  generate
    for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
      assign w_id[c]    = ship_map[c*ID_W +: ID_W];
      assign is_ship[c] = |w_id[c];
      assign w_own[c]   = (w_id[c] == r_sink_id);
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < NUM_SHIPS; k++) begin
      w_len[k] = '0;
      for (int c = 0; c < NUM_CELLS; c++) begin
        if (w_id[c] == ID_W'(k + 1)) w_len[k] = w_len[k] + CNT_W'(1);
      end
    end
  end

  // Out-of-range coordinates alias onto arbitrary indices; w_valid masks them.
  always_comb begin
    w_in_range = (int'(target_row) < GRID_N) && (int'(target_col) < GRID_N);
    w_idx      = IDX_W'(target_row) * IDX_W'(GRID_N) + IDX_W'(target_col);
    w_tid      = w_id[w_idx];
    w_tk       = w_tid - ID_W'(1);
    w_valid    = w_in_range && !r_fired[w_idx];
    w_sink_k   = r_sink_id - ID_W'(1);
  end

`ifdef ADJACENT_SINK_EN
  always_comb begin
    w_sink_mask = w_own;
    for (int r = 0; r < GRID_N; r++) begin
      for (int c = 0; c < GRID_N; c++) begin
        if (w_id[r*GRID_N + c] == '0) begin
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              if ((r + dr >= 0) && (r + dr < GRID_N) && (c + dc >= 0) && (c + dc < GRID_N)) begin
                if (w_own[(r + dr)*GRID_N + c + dc]) w_sink_mask[r*GRID_N + c] = 1'b1;
              end
            end
          end
        end
      end
    end
  end
`else
  assign w_sink_mask = w_own;
`endif

  always_comb begin
    ships_left = ID_W'(NUM_SHIPS);
    for (int k = 0; k < NUM_SHIPS; k++) begin
      ships_left = ships_left - ID_W'(r_sunk[k]);
    end
  end

  // Resolution happens on the accepting edge so the registered shot/result
  // strobes appear during the RESOLVE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_shot         <= '0;
      r_sunk_mask    <= '0;
      r_fired        <= '0;
      r_result_valid <= 1'b0;
      r_result       <= c_RES_MISS;
      r_game_over    <= 1'b0;
      r_sunk         <= '0;
      r_sink_pend    <= 1'b0;
      r_sink_id      <= '0;
      for (int k = 0; k < NUM_SHIPS; k++) r_hit[k] <= '0;
    end else begin
      r_shot         <= '0;
      r_sunk_mask    <= '0;
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fire) begin
            r_state     <= S_RESOLVE;
            r_sink_pend <= 1'b0;
            if (!w_valid) begin
              r_result       <= c_RES_INVALID;
              r_result_valid <= 1'b1;
            end else begin
              r_shot         <= NUM_CELLS'(1) << w_idx;
              r_fired[w_idx] <= 1'b1;
              if (w_tid == '0) begin
                r_result       <= c_RES_MISS;
                r_result_valid <= 1'b1;
              end else begin
                if (r_hit[w_tk] < w_len[w_tk]) r_hit[w_tk] <= r_hit[w_tk] + CNT_W'(1);
                if (r_hit[w_tk] + CNT_W'(1) >= w_len[w_tk]) begin
                  r_sink_pend <= 1'b1;
                  r_sink_id   <= w_tid;
                end else begin
                  r_result       <= c_RES_HIT;
                  r_result_valid <= 1'b1;
                end
              end
            end
          end
        end
        S_RESOLVE: begin
          if (r_sink_pend) begin
            r_state            <= S_SINK;
            r_sink_pend        <= 1'b0;
            r_sunk_mask        <= w_sink_mask;
            r_sunk[w_sink_k]   <= 1'b1;
            r_result           <= c_RES_SUNK;
            r_result_valid     <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SINK: begin
          if (&r_sunk) begin
            r_state     <= S_OVER;
            r_game_over <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_OVER:  r_state <= S_OVER;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign shot         = r_shot;
  assign ship_sunk    = r_sunk_mask;
  assign result_valid = r_result_valid;
  assign result       = r_result;
  assign game_over    = r_game_over;
  assign busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shot_resolver.sv
// ============================================================================
//  Module   : tb_shot_resolver
//  Purpose  : Scoreboard bench for shot_resolver; honours ADJACENT_SINK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shot_resolver;

  localparam int GRID_N    = 10;
  localparam int NUM_SHIPS = 5;
  localparam int ID_W      = 3;
  localparam int NUM_CELLS = GRID_N * GRID_N;

  localparam logic [1:0] K_MISS = 2'b00;
  localparam logic [1:0] K_HIT  = 2'b01;
  localparam logic [1:0] K_SUNK = 2'b10;
  localparam logic [1:0] K_INV  = 2'b11;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          fire;
  logic [3:0]                    target_row;
  logic [3:0]                    target_col;
  logic [NUM_CELLS*ID_W-1:0]     ship_map;
  logic [NUM_CELLS-1:0]          shot;
  logic [NUM_CELLS-1:0]          is_ship;
  logic [NUM_CELLS-1:0]          ship_sunk;
  logic                          busy;
  logic                          result_valid;
  logic [1:0]                    result;
  logic [ID_W-1:0]               ships_left;
  logic                          game_over;

  typedef struct {
    int                   cyc;
    logic [1:0]           res;
    logic [NUM_CELLS-1:0] mask;
    logic [ID_W-1:0]      left;
  } res_t;

  typedef struct {
    int cyc;
    int idx;
  } shot_t;

  res_t  res_q[$];
  shot_t shot_q[$];
  res_t  m_res;
  shot_t m_shot;

  int tb_id [NUM_CELLS];
  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int exp_left = NUM_SHIPS;

  shot_resolver #(.GRID_N(GRID_N), .NUM_SHIPS(NUM_SHIPS), .ID_W(ID_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .fire        (fire),
    .target_row  (target_row),
    .target_col  (target_col),
    .ship_map    (ship_map),
    .shot        (shot),
    .is_ship     (is_ship),
    .ship_sunk   (ship_sunk),
    .busy        (busy),
    .result_valid(result_valid),
    .result      (result),
    .ships_left  (ships_left),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NUM_CELLS-1:0] sink_mask(input int k);
    logic [NUM_CELLS-1:0] m = '0;
    for (int r = 0; r < GRID_N; r++) begin
      for (int c = 0; c < GRID_N; c++) begin
        if (tb_id[r*GRID_N + c] == k) m[r*GRID_N + c] = 1'b1;
`ifdef ADJACENT_SINK_EN
        else if (tb_id[r*GRID_N + c] == 0) begin
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if (r + dr >= 0 && r + dr < GRID_N && c + dc >= 0 && c + dc < GRID_N)
                if (tb_id[(r + dr)*GRID_N + c + dc] == k) m[r*GRID_N + c] = 1'b1;
        end
`endif
      end
    end
    return m;
  endfunction

  // Monitor: every visible strobe must match the head of its queue.
  always @(negedge clk) begin
    if (result_valid) begin
      chk("result_expected", 128'(res_q.size() != 0), 128'd1);
      if (res_q.size() != 0) begin
        m_res = res_q.pop_front();
        chk("result_cycle", 128'(m_res.cyc), 128'(cyc));
        chk("result_code", 128'(result), 128'(m_res.res));
        chk("ship_sunk_mask", 128'(ship_sunk), 128'(m_res.mask));
        chk("ships_left", 128'(ships_left), 128'(m_res.left));
      end
    end else begin
      chk("ship_sunk_quiet", 128'(ship_sunk), 128'd0);
    end
    if (shot != '0) begin
      chk("shot_expected", 128'(shot_q.size() != 0), 128'd1);
      if (shot_q.size() != 0) begin
        m_shot = shot_q.pop_front();
        chk("shot_cycle", 128'(m_shot.cyc), 128'(cyc));
        chk("shot_vector", 128'(shot), 128'(NUM_CELLS'(1) << m_shot.idx));
      end
    end
  end

  task automatic push_res(input int c, input logic [1:0] r, input logic [NUM_CELLS-1:0] m);
    res_t e;
    e.cyc = c; e.res = r; e.mask = m; e.left = ID_W'(exp_left);
    res_q.push_back(e);
  endtask

  task automatic push_shot(input int c, input int idx);
    shot_t e;
    e.cyc = c; e.idx = idx;
    shot_q.push_back(e);
  endtask

  task automatic do_fire(input int row, input int col, input logic [1:0] kind);
    int acc;
    int idx;
    idx        = row*GRID_N + col;
    fire       = 1'b1;
    target_row = 4'(row);
    target_col = 4'(col);
    @(posedge clk); #1;
    acc  = cyc;
    fire = 1'b0;
    if (kind != K_INV) push_shot(acc, idx);
    if (kind == K_SUNK) begin
      exp_left--;
      push_res(acc + 1, K_SUNK, sink_mask(tb_id[idx]));
    end else begin
      push_res(acc, kind, '0);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    bit found;
    for (int c = 0; c < NUM_CELLS; c++) tb_id[c] = 0;
    tb_id[0]  = 2; tb_id[1]  = 2;
    tb_id[55] = 1; tb_id[56] = 1; tb_id[57] = 1;
    tb_id[70] = 3; tb_id[80] = 3;
    tb_id[99] = 4;
    tb_id[40] = 5; tb_id[41] = 5; tb_id[42] = 5; tb_id[43] = 5;
    for (int c = 0; c < NUM_CELLS; c++) ship_map[c*ID_W +: ID_W] = ID_W'(tb_id[c]);
    for (int k = 1; k <= NUM_SHIPS; k++) begin
      found = 1'b0;
      for (int c = 0; c < NUM_CELLS; c++) if (tb_id[c] == k) found = 1'b1;
      if (!found) begin
        $display("FAIL config: ship id %0d absent from ship_map", k);
        $fatal(1, "configuration error");
      end
    end

    reset = 1'b1; fire = 1'b0; target_row = '0; target_col = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_shot", 128'(shot), 128'd0);
    chk("reset_result_valid", 128'(result_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_game_over", 128'(game_over), 128'd0);
    chk("reset_result", 128'(result), 128'd0);
    chk("reset_ships_left", 128'(ships_left), 128'd5);
    chk("is_ship_map", 128'(is_ship[1:0]), 128'd3);

    // Water at (2,3): strobe and result in the cycle after acceptance.
    fire = 1'b1; target_row = 4'd2; target_col = 4'd3;
    @(posedge clk); #1;
    acc = cyc; fire = 1'b0;
    push_shot(acc, 23);
    push_res(acc, K_MISS, '0);
    chk("busy_resolve", 128'(busy), 128'd1);
    @(posedge clk); #1;
    chk("busy_back_idle", 128'(busy), 128'd0);
    repeat (2) @(posedge clk);
    #1;

    do_fire(0, 0, K_HIT);
    do_fire(0, 1, K_SUNK);
    do_fire(0, 0, K_INV);
    do_fire(10, 0, K_INV);
    do_fire(3, 12, K_INV);
    chk("ships_left_after_invalid", 128'(ships_left), 128'd4);

    // Held fire: accepted only on IDLE visits (every other edge for a miss).
    fire = 1'b1; target_row = 4'd2; target_col = 4'd4;
    @(posedge clk); #1;
    acc = cyc;
    push_shot(acc, 24);
    push_res(acc, K_MISS, '0);
    push_res(acc + 2, K_INV, '0);
    push_res(acc + 4, K_INV, '0);
    repeat (4) @(posedge clk);
    #1 fire = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    do_fire(5, 5, K_HIT);
    do_fire(5, 6, K_HIT);
    do_fire(5, 7, K_SUNK);
    do_fire(7, 0, K_HIT);
    do_fire(8, 0, K_SUNK);
    do_fire(9, 9, K_SUNK);
    do_fire(4, 0, K_HIT);
    do_fire(4, 1, K_HIT);
    do_fire(4, 2, K_HIT);
    do_fire(4, 3, K_SUNK);
    chk("game_over_set", 128'(game_over), 128'd1);
    chk("busy_in_over", 128'(busy), 128'd1);

    fire = 1'b1; target_row = 4'd3; target_col = 4'd3;
    repeat (4) @(posedge clk);
    #1 fire = 1'b0;
    chk("game_over_sticky", 128'(game_over), 128'd1);

    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_left = NUM_SHIPS;
    chk("reset_clears_game_over", 128'(game_over), 128'd0);
    chk("reset_restores_ships", 128'(ships_left), 128'd5);
    chk("reset_idle", 128'(busy), 128'd0);
    do_fire(2, 3, K_MISS);
    do_fire(0, 0, K_HIT);

    // Reset lands between RESOLVE and SINK: the sink must never appear.
    fire = 1'b1; target_row = 4'd9; target_col = 4'd9;
    @(posedge clk); #1;
    acc = cyc; fire = 1'b0;
    push_shot(acc, 99);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_ships_left", 128'(ships_left), 128'd5);
    repeat (2) @(posedge clk);
    #1;
    do_fire(9, 9, K_SUNK);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 128'(res_q.size() + shot_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
